// File: rtl/player_input.sv
// 4x4 active-low keypad scanner with whole-frame debounce. Produces the latched
// one-hot player position, a start pulse and a key-present flag for game_controller.
module player_input #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_row,
  input  logic       pos_rst,
  output logic [3:0] kp_col,
  output logic [8:0] box,
  output logic       start_op,
  output logic       key_down
);

  localparam int             CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CYC_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     STABLE_MAX = 4'(DEBOUNCE_FRAMES);
  localparam logic [8:0]     BOX_CENTRE = 9'b000010000;
  localparam int             START_BIT  = 3;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   frame_q, frame_d;
  logic [15:0]   prev_q, prev_d;
  logic [15:0]   commit_frame_q, commit_frame_d;
  logic [3:0]    stable_q, stable_d;
  logic          commit_q, commit_d;
  logic [8:0]    box_q, box_d;
  logic          start_q, start_d;
  logic          start_dly_q, start_dly_d;
  logic          key_down_q, key_down_d;

  logic          col_last;
  logic          frame_end;
  logic [15:0]   frame_new;
  logic [8:0]    cells;
  logic          one_cell;

  // Cell key (r, c) sits at frame bit 4r+c and maps to position bit 3r+c.
  for (genvar gi = 0; gi < 9; gi++) begin : g_cell
    assign cells[gi] = commit_frame_q[4*(gi/3) + (gi%3)];
  end

  assign one_cell = (cells != 9'd0) && ((cells & (cells - 9'd1)) == 9'd0);

  always_comb begin
    col_last       = (cyc_q == CYC_LAST);
    frame_end      = col_last && (col_q == 2'd3);
    cyc_d          = col_last ? '0 : cyc_q + 1'b1;
    col_d          = col_last ? col_q + 2'd1 : col_q;

    frame_new      = frame_q;
    if (col_last) begin
      for (int r = 0; r < 4; r++) begin
        frame_new[{2'(r), col_q}] = ~row_sync_q[r];
      end
    end
    frame_d        = frame_new;

    prev_d         = prev_q;
    stable_d       = stable_q;
    commit_frame_d = commit_frame_q;
    commit_d       = 1'b0;
    if (frame_end) begin
      prev_d = frame_new;
      if (frame_new != prev_q) begin
        stable_d = 4'd0;
      end else if (stable_q != STABLE_MAX) begin
        stable_d = stable_q + 4'd1;
      end
      // Commit only on the edge where the count first reaches the threshold.
      if (stable_d == STABLE_MAX && stable_q != STABLE_MAX && frame_new != commit_frame_q) begin
        commit_frame_d = frame_new;
        commit_d       = 1'b1;
      end
    end

    box_d = box_q;
    if (pos_rst) begin
      box_d = BOX_CENTRE;
    end else if (commit_q && one_cell) begin
      box_d = cells;
    end

    start_dly_d = commit_frame_q[START_BIT];
    start_d     = commit_frame_q[START_BIT] & ~start_dly_q;
    key_down_d  = |commit_frame_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q     <= 4'hF;
      row_sync_q     <= 4'hF;
      cyc_q          <= '0;
      col_q          <= 2'd0;
      frame_q        <= 16'd0;
      prev_q         <= 16'd0;
      commit_frame_q <= 16'd0;
      stable_q       <= 4'd0;
      commit_q       <= 1'b0;
      box_q          <= BOX_CENTRE;
      start_q        <= 1'b0;
      start_dly_q    <= 1'b0;
      key_down_q     <= 1'b0;
    end else begin
      row_meta_q     <= kp_row;
      row_sync_q     <= row_meta_q;
      cyc_q          <= cyc_d;
      col_q          <= col_d;
      frame_q        <= frame_d;
      prev_q         <= prev_d;
      commit_frame_q <= commit_frame_d;
      stable_q       <= stable_d;
      commit_q       <= commit_d;
      box_q          <= box_d;
      start_q        <= start_d;
      start_dly_q    <= start_dly_d;
      key_down_q     <= key_down_d;
    end
  end

  assign kp_col   = ~(4'b0001 << col_q);
  assign box      = box_q;
  assign start_op = start_q;
  assign key_down = key_down_q;

endmodule

// File: tb/tb_player_input.sv
// Scoreboard bench for player_input: stimulus pushes expected box/start events,
// a negedge monitor pops and compares whenever box changes or start_op fires.
module tb_player_input;

  localparam logic [8:0] CENTRE = 9'b000010000;

  typedef struct packed {
    logic       is_start;
    logic [8:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] kp_row;
  logic       pos_rst;
  logic [3:0] kp_col;
  logic [8:0] box;
  logic       start_op;
  logic       key_down;

  logic [15:0] pressed;
  ev_t         exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_box_cyc = 0;
  logic [8:0]  mon_box;
  logic        mon_start;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  player_input #(.SCAN_DIV(8), .DEBOUNCE_FRAMES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .kp_row   (kp_row),
    .pos_rst  (pos_rst),
    .kp_col   (kp_col),
    .box      (box),
    .start_op (start_op),
    .key_down (key_down)
  );

  // Keypad: a closed key pulls its row low while its column is driven low.
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_col[c] && pressed[4*r+c]) kp_row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic check_event(input logic is_start, input logic [8:0] val);
    ev_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got start=%0b box=%b, required no event", is_start, val);
    end else begin
      e = exp_q.pop_front();
      if (e.is_start != is_start || (!is_start && e.val !== val)) begin
        n_fail++;
        $display("FAIL event: got start=%0b box=%b, required start=%0b box=%b",
                 is_start, val, e.is_start, e.val);
      end else begin
        $display("ok   event at cycle %0d: start=%0b box=%b", cyc, is_start, val);
      end
    end
  endtask

  task automatic push_ev(input logic is_start, input logic [8:0] val);
    ev_t e;
    e.is_start = is_start;
    e.val      = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("ok   %s: all expected events seen", name);
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon_box   = box;
      mon_start = 1'b0;
    end else begin
      if (box !== mon_box) begin
        last_box_cyc = cyc;
        check_event(1'b0, box);
        mon_box = box;
      end
      if (mon_start) chk("start_width", {15'd0, start_op}, 16'd0);
      else if (start_op) check_event(1'b1, 9'd0);
      mon_start = start_op;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_seq [4];
    int t0, lat, n;
    col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;

    rst = 1'b0; pressed = 16'd0; pos_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_kp_col",   {12'd0, kp_col}, 16'b1110);
    chk("rst_box",      {7'd0, box}, {7'd0, CENTRE});
    chk("rst_start_op", {15'd0, start_op}, 16'd0);
    chk("rst_key_down", {15'd0, key_down}, 16'd0);
    rst = 1'b1;
    chk("scan_col0", {12'd0, kp_col}, 16'b1110);
    for (int k = 0; k < 4; k++) begin
      repeat (8) @(posedge clk);
      #1 chk("scan_step", {12'd0, kp_col}, {12'd0, col_seq[k]});
    end
    @(negedge clk);

    // Single press of (r1,c2), held 8 frames then released.
    push_ev(1'b0, 9'b000100000);
    pressed[6] = 1'b1;
    t0 = cyc;
    wait_drain("press_commit", 200);
    lat = last_box_cyc - t0;
    chk("press_latency_ok", {15'd0, (lat >= 96 && lat <= 163)}, 16'd1);
    while (cyc < t0 + 256) @(negedge clk);
    chk("press_key_down", {15'd0, key_down}, 16'd1);
    pressed[6] = 1'b0;
    repeat (192) @(negedge clk);
    chk("release_key_down", {15'd0, key_down}, 16'd0);
    chk("release_box_held", {7'd0, box}, 16'b000100000);

    // Bouncy (r2,c0): phase the toggling just after a column-0 sample.
    n = 0;
    while (kp_col != 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (kp_col != 4'b1101 && n < 128) begin @(negedge clk); n++; end
    chk("bounce_align", {12'd0, kp_col}, 16'b1101);
    push_ev(1'b0, 9'b001000000);
    for (int i = 0; i < 10; i++) begin
      pressed[8] = (i % 2 == 0);
      repeat (20) @(negedge clk);
    end
    pressed[8] = 1'b1;
    t0 = cyc;
    wait_drain("bounce_commit", 400);
    lat = last_box_cyc - t0;
    chk("bounce_latency_ok", {15'd0, (lat >= 128 && lat <= 200)}, 16'd1);
    pressed[8] = 1'b0;
    repeat (192) @(negedge clk);

    // Start key: two presses, two pulses, none on release.
    push_ev(1'b1, 9'd0);
    pressed[3] = 1'b1;
    repeat (320) @(negedge clk);
    wait_drain("start_first", 1);
    pressed[3] = 1'b0;
    repeat (192) @(negedge clk);
    push_ev(1'b1, 9'd0);
    pressed[3] = 1'b1;
    repeat (320) @(negedge clk);
    wait_drain("start_second", 1);
    pressed[3] = 1'b0;
    repeat (192) @(negedge clk);
    chk("start_release_key_down", {15'd0, key_down}, 16'd0);

    // Two cell keys together leave box alone; pos_rst centres it.
    pressed[0] = 1'b1; pressed[10] = 1'b1;
    repeat (256) @(negedge clk);
    chk("multi_key_down", {15'd0, key_down}, 16'd1);
    chk("multi_box_held", {7'd0, box}, 16'b001000000);
    push_ev(1'b0, CENTRE);
    pos_rst = 1'b1;
    @(posedge clk);
    #1 chk("pos_rst_box", {7'd0, box}, {7'd0, CENTRE});
    @(negedge clk);
    pos_rst = 1'b0;
    wait_drain("pos_rst_event", 5);
    pressed[0] = 1'b0; pressed[10] = 1'b0;
    repeat (192) @(negedge clk);

    // Reset mid-debounce of (r0,c1), key held throughout.
    pressed[1] = 1'b1;
    repeat (70) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_kp_col",   {12'd0, kp_col}, 16'b1110);
    chk("mid_rst_box",      {7'd0, box}, {7'd0, CENTRE});
    chk("mid_rst_start_op", {15'd0, start_op}, 16'd0);
    chk("mid_rst_key_down", {15'd0, key_down}, 16'd0);
    push_ev(1'b0, 9'b000000010);
    rst = 1'b1;
    t0 = cyc;
    wait_drain("post_rst_commit", 250);
    lat = last_box_cyc - t0;
    chk("post_rst_latency_ok", {15'd0, (lat >= 128 && lat <= 163)}, 16'd1);
    pressed[1] = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
